roi_capture_ctrl: RTL and testbench
===================================

// Module: roi_capture_ctrl
// PURPOSE
//  Sequences region-of-interest (ROI) capture on a monitored AXI4-Stream video bus.
//  - Software arms it with an ROI rectangle and a frame count.
//  - It waits for start-of-frame, then flags each accepted beat inside the ROI with capture_beat.
//  - It counts completed ROI frames and stops after num_frames of them.
//  - capture_beat drives the write enable of the debug capture buffer beside the frame/line/pixel counters.
// PARAMETERS
//  MAX_HSIZE  1920  max active pixels per line; XW = $clog2(MAX_HSIZE)+1
//  MAX_VSIZE  1080  max active lines per frame;  YW = $clog2(MAX_VSIZE)+1
// PORTS
//  aclk           in   1   clock
//  resetn         in   1   synchronous reset, active-low
//  s_axis_tvalid  in   1   monitored stream valid
//  s_axis_tready  in   1   monitored stream ready
//  s_axis_tlast   in   1   end of line (EOL)
//  s_axis_tuser   in   1   start of frame (SOF)
//  arm            in   1   start request, single-cycle pulse
//  abort          in   1   stop request, single-cycle pulse
//  roi_x, roi_w   in   XW  ROI start column / width
//  roi_y, roi_h   in   YW  ROI start line / height
//  num_frames     in   8   frames to capture; 0 is treated as 1
//  capture_beat   out  1   current accepted beat lies inside the ROI (combinational)
//  busy           out  1   state is ARMED or CAPTURE
//  done           out  1   1-cycle pulse when the capture completes
//  frames_done    out  8   ROI frames completed since the last accepted arm
//  err_short      out  1   sticky: SOF arrived before the ROI frame completed
// BEHAVIOUR
//  Definitions
//  - beat = tvalid & tready;  sof = beat & tuser;  eol = beat & tlast.
//  Position (x, y)
//  - x, y are the position of the current beat. A sof beat is at (0,0).
//  - x increments per beat and clears after eol. y increments after eol.
//  - x saturates at all-ones; it never wraps.
//  - x and y track at all times, in every state.
//  Reset
//  - State IDLE; busy, done, err_short and capture_beat are 0; frames_done is 0.
//  ROI window
//  - Config (roi_*, num_frames) is latched when arm is accepted. Later input changes are ignored.
//  - Inside window: roi_x <= x < roi_x+roi_w and roi_y <= y < roi_y+roi_h.
//  - Window end sums are computed one bit wider (XW+1, YW+1), so there is no overflow.
//  - roi_w == 0 or roi_h == 0 gives an empty window. Frames are still counted.
//  FSM: IDLE -> ARMED -> CAPTURE -> DONE -> IDLE
//  - IDLE: arm accepted -> ARMED next cycle. On accept: latch config, clear frames_done and err_short.
//  - ARMED: on sof -> CAPTURE. That sof beat is already evaluated against the window.
//  - CAPTURE: capture_beat = beat & inside window.
//  - CAPTURE, frame complete: eol with y == roi_y+roi_h-1 (or y == roi_y if roi_h == 0), then frames_done += 1.
//    - If frames_done reaches num_frames -> DONE.
//    - Otherwise -> ARMED, which waits for the next sof.
//  - CAPTURE, sof before frame complete: err_short set; frame not counted; stay in CAPTURE.
//    Capture restarts at (0,0) on that beat.
//  - DONE: done = 1 for exactly one cycle, then IDLE. frames_done holds until the next accepted arm.
//  - ROI lying beyond the actual frame: only the next sof ends the frame, so err_short is set.
//  Latency
//  - capture_beat: 0 cycles, same cycle as the beat.
//  - busy: rises the cycle after arm; falls the cycle after the completing eol.
//  - done: pulses the cycle after the completing eol.
//  Priority and simultaneous events
//  - abort in any state -> IDLE next cycle. capture_beat is forced 0 in the abort cycle.
//  - No done pulse on abort; frames_done holds.
//  - arm while not in IDLE is ignored.
//  - arm and abort in the same cycle: abort wins.
//  - Reset mid-capture: immediate return to the reset values at the next edge.
// TESTING
//  T1 Single frame 8x4, ROI x=2,y=1,w=3,h=2, num=1.
//     -> capture_beat on exactly 6 beats, (2..4, 1..2); done pulses after the line-2 eol; frames_done = 1.
//  T2 num=3, back-to-back 8x4 frames with random tvalid/tready gaps.
//     -> 18 capture_beats total; frames_done goes 1, 2, 3; one done; busy low afterwards.
//  T3 ROI y=3,h=2 on a 4-line frame.
//     -> next sof sets err_short; frames_done stays 0; busy stays 1.
//  T4 abort mid-line during CAPTURE.
//     -> capture_beat 0 that cycle; IDLE next cycle; no done; frames_done unchanged.
//  T5 num_frames=0, roi_w=0.
//     -> behaves as num=1; zero capture_beats; done after frame 0's last-ROI-line eol.
//  T6 arm pulsed while busy; arm+abort together in IDLE; resetn low in CAPTURE.
//     -> arm ignored; stays IDLE; all outputs return to reset values.

Source files
------------

// File: rtl/roi_capture_ctrl.sv
// ROI capture sequencer for a monitored AXI4-Stream video bus.
// Flags in-window beats of up to num_frames consecutive frames and reports progress and errors.
module roi_capture_ctrl #(
    parameter int MAX_HSIZE = 1920,
    parameter int MAX_VSIZE = 1080,
    localparam int XW = $clog2(MAX_HSIZE) + 1,
    localparam int YW = $clog2(MAX_VSIZE) + 1
) (
    input  logic          aclk,
    input  logic          resetn,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tready,
    input  logic          s_axis_tlast,
    input  logic          s_axis_tuser,
    input  logic          arm,
    input  logic          abort,
    input  logic [XW-1:0] roi_x,
    input  logic [XW-1:0] roi_w,
    input  logic [YW-1:0] roi_y,
    input  logic [YW-1:0] roi_h,
    input  logic [7:0]    num_frames,
    output logic          capture_beat,
    output logic          busy,
    output logic          done,
    output logic [7:0]    frames_done,
    output logic          err_short
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;

    logic          beat_s;
    logic          sof_s;
    logic          eol_s;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic [XW-1:0] cur_x_s;
    logic [YW-1:0] cur_y_s;

    logic [XW-1:0] roi_x_r;
    logic [XW-1:0] roi_w_r;
    logic [YW-1:0] roi_y_r;
    logic [YW-1:0] roi_h_r;
    logic [7:0]    num_r;

    logic [XW:0]   x_end_s;
    logic [YW:0]   y_end_s;
    logic [YW:0]   last_y_s;
    logic          in_win_s;
    logic          cap_active_s;
    logic          frame_cmp_s;
    logic          arm_ok_s;
    logic [7:0]    fd_inc_s;

    logic [7:0]    frames_done_r;
    logic          err_short_r;
    logic          busy_r;
    logic          done_r;

    // Beat qualification and position of the beat currently on the bus
    always_comb begin
        beat_s  = s_axis_tvalid & s_axis_tready;
        sof_s   = beat_s & s_axis_tuser;
        eol_s   = beat_s & s_axis_tlast;
        cur_x_s = sof_s ? {XW{1'b0}} : x_r;
        cur_y_s = sof_s ? {YW{1'b0}} : y_r;
    end

    // Position tracker runs in every state; x saturates instead of wrapping
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            x_r <= {XW{1'b0}};
            y_r <= {YW{1'b0}};
        end else if (beat_s) begin
            if (eol_s) begin
                x_r <= {XW{1'b0}};
                y_r <= cur_y_s + YW'(1);
            end else begin
                x_r <= (cur_x_s == {XW{1'b1}}) ? cur_x_s : cur_x_s + XW'(1);
                y_r <= cur_y_s;
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    // Window bounds use one extra bit so start+size can never overflow
    always_comb begin
        x_end_s  = {1'b0, roi_x_r} + {1'b0, roi_w_r};
        y_end_s  = {1'b0, roi_y_r} + {1'b0, roi_h_r};
        last_y_s = (roi_h_r == {YW{1'b0}}) ? {1'b0, roi_y_r} : (y_end_s - (YW + 1)'(1));
        in_win_s = (cur_x_s >= roi_x_r) & ({1'b0, cur_x_s} < x_end_s) &
                   (cur_y_s >= roi_y_r) & ({1'b0, cur_y_s} < y_end_s);
    end

    // The sof that releases ARMED is already part of the captured frame
    always_comb begin
        cap_active_s = ((state_r == S_CAPTURE) & beat_s) | ((state_r == S_ARMED) & sof_s);
        frame_cmp_s  = cap_active_s & eol_s & ({1'b0, cur_y_s} == last_y_s);
        arm_ok_s     = (state_r == S_IDLE) & arm & ~abort;
        fd_inc_s     = frames_done_r + 8'd1;
        capture_beat = resetn & ~abort & cap_active_s & in_win_s;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nx_s = state_r;
        if (abort) begin
            state_nx_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (arm) begin
                        state_nx_s = S_ARMED;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_ARMED, S_CAPTURE: begin
                    if (frame_cmp_s) begin
                        state_nx_s = (fd_inc_s == num_r) ? S_DONE : S_ARMED;
                    end else if (cap_active_s) begin
                        state_nx_s = S_CAPTURE;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                S_DONE: begin
                    state_nx_s = S_IDLE;
                end
                default: begin
                    state_nx_s = S_IDLE;
                end
            endcase
        end
    end

    // State register and registered status flags
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == S_ARMED) | (state_nx_s == S_CAPTURE);
            done_r  <= (state_nx_s == S_DONE);
        end
    end

    // Config latch on accepted arm, frame counter and sticky short-frame flag
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            roi_x_r       <= {XW{1'b0}};
            roi_w_r       <= {XW{1'b0}};
            roi_y_r       <= {YW{1'b0}};
            roi_h_r       <= {YW{1'b0}};
            num_r         <= 8'd1;
            frames_done_r <= 8'd0;
            err_short_r   <= 1'b0;
        end else if (arm_ok_s) begin
            roi_x_r       <= roi_x;
            roi_w_r       <= roi_w;
            roi_y_r       <= roi_y;
            roi_h_r       <= roi_h;
            num_r         <= (num_frames == 8'd0) ? 8'd1 : num_frames;
            frames_done_r <= 8'd0;
            err_short_r   <= 1'b0;
        end else begin
            if (frame_cmp_s & ~abort) begin
                frames_done_r <= fd_inc_s;
            end else begin
                frames_done_r <= frames_done_r;
            end
            if ((state_r == S_CAPTURE) & sof_s & ~abort) begin
                err_short_r <= 1'b1;
            end else begin
                err_short_r <= err_short_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign frames_done = frames_done_r;
    assign err_short   = err_short_r;

endmodule

// File: tb/tb_roi_capture_ctrl.sv
// Randomized bench for roi_capture_ctrl against a cycle-level behavioural model.
module tb_roi_capture_ctrl;

    logic        aclk = 1'b0;
    logic        resetn;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic        arm, abort;
    logic [11:0] roi_x, roi_w, roi_y, roi_h;
    logic [7:0]  num_frames;
    logic        capture_beat, busy, done, err_short;
    logic [7:0]  frames_done;

    int total = 0;
    int bad   = 0;

    // model state: 0 idle, 1 waiting for sof, 2 capturing, 3 done
    int m_state, m_x, m_y, m_fd, m_err;
    int c_x, c_y, c_w, c_h, c_n;
    bit chk_en;
    int cap_cnt, done_cnt;

    always #5 aclk = ~aclk;

    roi_capture_ctrl dut (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .arm(arm), .abort(abort),
        .roi_x(roi_x), .roi_w(roi_w), .roi_y(roi_y), .roi_h(roi_h),
        .num_frames(num_frames),
        .capture_beat(capture_beat), .busy(busy), .done(done),
        .frames_done(frames_done), .err_short(err_short)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs mid-cycle, advance the model, then release pulses
    task automatic step();
        int  bt, sf, el, px, py, lasty, act, inwin, expc;
        #4;
        bt    = s_axis_tvalid & s_axis_tready;
        sf    = bt & s_axis_tuser;
        el    = bt & s_axis_tlast;
        px    = sf ? 0 : m_x;
        py    = sf ? 0 : m_y;
        act   = (m_state == 2 && bt) || (m_state == 1 && sf);
        inwin = (px >= c_x) && (px < c_x + c_w) && (py >= c_y) && (py < c_y + c_h);
        lasty = (c_h == 0) ? c_y : c_y + c_h - 1;
        expc  = resetn && !abort && act && inwin;
        if (chk_en) begin
            check_val("capture_beat", capture_beat, expc);
            check_val("busy", busy, (m_state == 1 || m_state == 2));
            check_val("done", done, (m_state == 3));
            check_val("frames_done", frames_done, m_fd);
            check_val("err_short", err_short, m_err);
        end
        cap_cnt  += capture_beat;
        done_cnt += done;
        if (!resetn) begin
            m_state = 0; m_x = 0; m_y = 0; m_fd = 0; m_err = 0;
        end else begin
            if (bt) begin
                if (el) begin m_x = 0; m_y = (py + 1) % 4096; end
                else begin m_x = (px < 4095) ? px + 1 : 4095; m_y = py; end
            end
            if (abort) m_state = 0;
            else begin
                case (m_state)
                    0: if (arm) begin
                        c_x = roi_x; c_y = roi_y; c_w = roi_w; c_h = roi_h;
                        c_n = (num_frames == 0) ? 1 : num_frames;
                        m_fd = 0; m_err = 0; m_state = 1;
                    end
                    1, 2: begin
                        if (m_state == 2 && sf) m_err = 1;
                        if (act && el && py == lasty) begin
                            m_fd++;
                            m_state = (m_fd == c_n) ? 3 : 1;
                        end else if (act) m_state = 2;
                    end
                    default: m_state = 0;
                endcase
            end
        end
        @(posedge aclk);
        #1;
        arm = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Accept-time config followed by scrambled inputs, which must be ignored
    task automatic do_arm(input int x, input int y, input int w, input int h, input int n);
        roi_x = 12'(x); roi_y = 12'(y); roi_w = 12'(w); roi_h = 12'(h); num_frames = 8'(n);
        arm = 1'b1;
        step();
        roi_x = 12'($urandom_range(0, 15)); roi_y = 12'($urandom_range(0, 15));
        roi_w = 12'($urandom_range(0, 15)); roi_h = 12'($urandom_range(0, 15));
        num_frames = 8'($urandom_range(0, 5));
    endtask

    // ev_kind on beat ev_at: 1 abort, 2 arm, 3 reset
    task automatic send_frame(input int w, input int h, input bit gaps, input int ev_at, input int ev_kind);
        int n = 0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                bit got = 1'b0;
                int tries = 0;
                while (!got) begin
                    if (!gaps || n == ev_at || tries > 20) begin
                        s_axis_tvalid = 1'b1; s_axis_tready = 1'b1;
                    end else begin
                        s_axis_tvalid = ($urandom_range(0, 3) != 0);
                        s_axis_tready = ($urandom_range(0, 3) != 0);
                    end
                    s_axis_tuser = (xx == 0 && yy == 0);
                    s_axis_tlast = (xx == w - 1);
                    got = s_axis_tvalid & s_axis_tready;
                    if (got && n == ev_at) begin
                        case (ev_kind)
                            1: abort = 1'b1;
                            2: arm = 1'b1;
                            3: resetn = 1'b0;
                            default: ;
                        endcase
                    end
                    step();
                    resetn = 1'b1;
                    tries++;
                end
                n++;
            end
        end
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; arm = 1'b0; abort = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tready = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        roi_x = 12'd0; roi_y = 12'd0; roi_w = 12'd0; roi_h = 12'd0; num_frames = 8'd0;
        m_state = 0; m_x = 0; m_y = 0; m_fd = 0; m_err = 0;
        c_x = 0; c_y = 0; c_w = 0; c_h = 0; c_n = 1;
        chk_en = 1'b0; cap_cnt = 0; done_cnt = 0;
        step();
        chk_en = 1'b1;
        step();
        step();
        resetn = 1'b1;
        check_val("rst_busy", busy, 0);
        check_val("rst_fd", frames_done, 0);

        // T1: single 8x4 frame
        cap_cnt = 0; done_cnt = 0;
        do_arm(2, 1, 3, 2, 1);
        send_frame(8, 4, 1'b0, -1, 0);
        idle(3);
        check_val("t1_caps", cap_cnt, 6);
        check_val("t1_done", done_cnt, 1);
        check_val("t1_fd", frames_done, 1);

        // T2: three frames with random gaps
        cap_cnt = 0; done_cnt = 0;
        do_arm(2, 1, 3, 2, 3);
        for (int f = 0; f < 3; f++) begin
            send_frame(8, 4, 1'b1, -1, 0);
            idle($urandom_range(0, 2));
        end
        idle(3);
        check_val("t2_caps", cap_cnt, 18);
        check_val("t2_done", done_cnt, 1);
        check_val("t2_fd", frames_done, 3);
        check_val("t2_busy", busy, 0);

        // T3: ROI extends past the frame bottom
        do_arm(2, 3, 3, 2, 1);
        send_frame(8, 4, 1'b1, -1, 0);
        check_val("t3_err_pre", err_short, 0);
        send_frame(8, 1, 1'b1, -1, 0);
        check_val("t3_err", err_short, 1);
        check_val("t3_fd", frames_done, 0);
        check_val("t3_busy", busy, 1);
        abort = 1'b1;
        idle(2);

        // T4: abort on an in-window beat
        cap_cnt = 0; done_cnt = 0;
        do_arm(2, 1, 3, 2, 1);
        send_frame(8, 4, 1'b0, 11, 1);
        idle(2);
        check_val("t4_caps", cap_cnt, 1);
        check_val("t4_done", done_cnt, 0);
        check_val("t4_busy", busy, 0);
        check_val("t4_fd", frames_done, 0);

        // T5: zero frame count and empty window
        cap_cnt = 0; done_cnt = 0;
        do_arm(2, 1, 0, 2, 0);
        send_frame(8, 4, 1'b1, -1, 0);
        idle(2);
        check_val("t5_caps", cap_cnt, 0);
        check_val("t5_done", done_cnt, 1);
        check_val("t5_fd", frames_done, 1);

        // T6: arm while busy, arm with abort, reset during capture
        cap_cnt = 0; done_cnt = 0;
        do_arm(2, 1, 3, 2, 1);
        roi_x = 12'd0; roi_y = 12'd0; roi_w = 12'd8; roi_h = 12'd4; num_frames = 8'd2;
        send_frame(8, 4, 1'b1, 5, 2);
        idle(2);
        check_val("t6_caps", cap_cnt, 6);
        check_val("t6_done", done_cnt, 1);
        arm = 1'b1; abort = 1'b1;
        idle(2);
        check_val("t6_armabort", busy, 0);
        cap_cnt = 0; done_cnt = 0;
        do_arm(0, 0, 8, 4, 1);
        send_frame(8, 4, 1'b0, 12, 3);
        idle(2);
        check_val("t6_rst_caps", cap_cnt, 12);
        check_val("t6_rst_busy", busy, 0);
        check_val("t6_rst_done", done_cnt, 0);
        check_val("t6_rst_fd", frames_done, 0);

        // Random configurations and frame shapes against the model
        for (int it = 0; it < 25; it++) begin
            int fw, fh, nf;
            fw = $urandom_range(1, 8);
            fh = $urandom_range(1, 5);
            nf = $urandom_range(0, 2);
            do_arm($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9),
                   $urandom_range(0, 5), nf);
            for (int f = 0; f < nf + 2; f++) begin
                if ($urandom_range(0, 7) == 0)
                    send_frame(fw, fh, 1'b1, $urandom_range(0, fw * fh - 1), 1);
                else
                    send_frame(fw, fh, 1'b1, -1, 0);
                idle($urandom_range(0, 2));
            end
            abort = 1'b1;
            idle(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
